ps2_mouse_packet_decoder: RTL
=============================

// Module: ps2_mouse_packet_decoder
// PURPOSE
//  Sits directly downstream of the PS/2 byte receiver. Consumes its received_data/received_data_en byte stream.
//  Assembles standard PS/2 mouse movement packets and checks byte-0 sync.
//  Maintains a clamped screen cursor (320x240 default) and button states for the game/VGA logic.
//  Keyboard scan-code decoding stays outside this block.
// PARAMETERS
//  X_MAX          319     largest legal x_pos
//  Y_MAX          239     largest legal y_pos
//  X_INIT         160     x_pos after reset
//  Y_INIT         120     y_pos after reset
//  SHIFT_X        1       dx scaled by arithmetic right shift (>>>), no divider
//  SHIFT_Y        1       dy scaled by arithmetic right shift
//  TIMEOUT_CYCLES 100000  max idle clk cycles between bytes of one packet (2 ms @ 50 MHz)
// PORTS
//  clk            in   1   system clock, all logic on posedge
//  reset_n        in   1   asynchronous, active-low reset
//  received_data  in   8   byte from PS/2 receiver
//  received_data_en in 1   one-cycle strobe, received_data valid
//  x_pos          out  10  cursor x, 0..X_MAX
//  y_pos          out  9   cursor y, 0..Y_MAX, 0 = top
//  left_btn/right_btn/middle_btn out 1 each  button levels from last accepted packet
//  packet_valid   out  1   one-cycle pulse: position/buttons just updated
//  sync_error     out  1   one-cycle pulse: byte rejected or packet timed out
//  wheel_delta    out  4   signed wheel step of last packet (0 without PS2_MOUSE_WHEEL_EN)
// BEHAVIOUR
//  Reset: state=WAIT_B0, x_pos=X_INIT, y_pos=Y_INIT, buttons=0, packet_valid=0, sync_error=0, wheel_delta=0, timer=0.
//  FSM WAIT_B0 -> WAIT_B1 -> WAIT_B2 [-> WAIT_B3] -> WAIT_B0. Advances only on received_data_en.
//  WAIT_B0 handling:
//   - byte 0xFA (ACK) or 0xAA (BAT OK): dropped silently.
//   - byte with bit3=0: dropped, sync_error pulses.
//   - otherwise: latch byte0 and go to WAIT_B1.
//  WAIT_B1 latches dx low byte; WAIT_B2 latches dy low byte.
//  Final byte: outputs update on the clk edge after the strobe; packet_valid is high that cycle (latency 1).
//  Movement arithmetic:
//   - dx = {b0[4], b1}, dy = {b0[5], b2}, both 9-bit signed.
//   - sx = dx >>> SHIFT_X, sy = dy >>> SHIFT_Y.
//   - nx = x_pos + sx and ny = y_pos - sy, in 11-bit signed (PS/2 +y is up).
//   - Clamp: <0 -> 0; >X_MAX/Y_MAX -> X_MAX/Y_MAX.
//  Buttons: left=b0[0], right=b0[1], middle=b0[2].
//  Overflow: b0[6] or b0[7] set -> buttons still update, position held, packet_valid still pulses.
//  Timeout: 17-bit timer runs in every state except WAIT_B0 and clears on each strobe.
//   - Reaching TIMEOUT_CYCLES -> WAIT_B0, partial packet discarded, sync_error pulses.
//   - Strobe and expiry in the same cycle: the byte wins and the timer clears.
//  Reset asserted mid-packet: immediate return to reset values; partial packet is lost.
//  Strobe held high more than 1 cycle is illegal upstream; each high cycle counts as a byte.
// CONFIGURATION
//  PS2_MOUSE_WHEEL_EN defined:
//   - 4-byte IntelliMouse packets; WAIT_B3 added.
//   - wheel_delta = b3[3:0], registered with packet_valid.
//   - Timer is also active in WAIT_B3.
//  PS2_MOUSE_WHEEL_EN undefined:
//   - 3-byte packets, no WAIT_B3 state.
//   - wheel_delta tied to 4'h0.
// STRUCTURE
//  Package ps2_mouse_pkg:
//   - state enum {WAIT_B0, WAIT_B1, WAIT_B2, WAIT_B3}.
//   - constants PS2_ACK=8'hFA, PS2_BAT_OK=8'hAA, default screen limits/centre.
//  Sub-module ps2_axis_accumulator (params MAX, INIT, SHIFT, INVERT):
//   - 9-bit signed delta in, scale + add/sub + clamp, registered position out.
//   - Instantiated once for X and once for Y (INVERT=1).
//  Top level holds the FSM, byte latches, timer and pulse generation.
// TESTING
//  1 Reset: reset_n low then high -> x_pos=160, y_pos=120, buttons 0, no pulses.
//  2 Strobe bytes 08 10 08 (mid-packet gaps 0 and 99999 cycles, no timeout) -> x_pos=168, y_pos=116, left_btn=0; packet_valid 1 cycle after 3rd strobe.
//  3 Send 18 00 00 twice -> x_pos 32 then 0 (clamped low). Send 28 00 00 twice -> y_pos 239 (clamped high).
//  4 Strobe 00 in WAIT_B0 -> sync_error pulse, state WAIT_B0.
//    Strobe FA -> no pulse.
//    Then 09 00 00 -> left_btn=1.
//  5 Timeout: 08 10, then idle 100000 cycles -> sync_error pulse, state WAIT_B0.
//    Then 09 04 00 -> x_pos +2 from prior value.
//  6 Overflow: C9 7F 7F -> left_btn=1, position unchanged, packet_valid pulses.
//    With PS2_MOUSE_WHEEL_EN, 08 00 00 0F -> wheel_delta=4'hF (-1).

Source files
------------

// File: rtl/ps2_mouse_pkg.sv
// Shared types and constants for the PS/2 mouse packet decoder.
// Screen limits and the timeout default describe a 320x240 target clocked at 50 MHz.
package ps2_mouse_pkg;

    typedef enum logic [1:0] {
        WAIT_B0 = 2'd0,
        WAIT_B1 = 2'd1,
        WAIT_B2 = 2'd2,
        WAIT_B3 = 2'd3
    } state_t;

    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_BAT_OK = 8'hAA;

    localparam int X_MAX_DEF   = 319;
    localparam int Y_MAX_DEF   = 239;
    localparam int X_INIT_DEF  = 160;
    localparam int Y_INIT_DEF  = 120;
    localparam int TIMEOUT_DEF = 100000;

endpackage

// File: rtl/ps2_axis_accumulator.sv
// One cursor axis: scales a 9-bit signed mouse delta, applies it and clamps to 0..MAX.
// INVERT=1 subtracts the delta (PS/2 reports +y as up, the screen has 0 at the top).
module ps2_axis_accumulator #(
    parameter int W      = 10,
    parameter int MAX    = 319,
    parameter int INIT   = 160,
    parameter int SHIFT  = 1,
    parameter int INVERT = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              update,
    input  logic signed [8:0] delta,
    output logic [W-1:0]      pos
);

    logic signed [8:0]  scaled;
    logic signed [10:0] cur;
    logic signed [10:0] step;
    logic signed [10:0] nxt;

    // 11 bits signed covers 0..MAX plus or minus the largest scaled step
    always_comb begin
        scaled = delta >>> SHIFT;
        cur    = {{(11-W){1'b0}}, pos};
        step   = {{2{scaled[8]}}, scaled};
        nxt    = (INVERT != 0) ? (cur - step) : (cur + step);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pos <= W'(INIT);
        end else if (update) begin
            if (nxt < 0)
                pos <= '0;
            else if (nxt > 11'(MAX))
                pos <= W'(MAX);
            else
                pos <= nxt[W-1:0];
        end
    end

endmodule

// File: rtl/ps2_mouse_packet_decoder.sv
// Assembles PS/2 mouse packets into a clamped cursor position and button levels.
// Define PS2_MOUSE_WHEEL_EN for 4-byte IntelliMouse packets with a wheel byte.
//
// state   | meaning
// WAIT_B0 | idle, expecting a status byte with bit3 set
// WAIT_B1 | status latched, expecting dx low byte
// WAIT_B2 | expecting dy low byte (final byte without wheel)
// WAIT_B3 | expecting wheel byte (wheel build only)
module ps2_mouse_packet_decoder
    import ps2_mouse_pkg::*;
#(
    parameter int X_MAX          = X_MAX_DEF,
    parameter int Y_MAX          = Y_MAX_DEF,
    parameter int X_INIT         = X_INIT_DEF,
    parameter int Y_INIT         = Y_INIT_DEF,
    parameter int SHIFT_X        = 1,
    parameter int SHIFT_Y        = 1,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] received_data,
    input  logic       received_data_en,
    output logic [9:0] x_pos,
    output logic [8:0] y_pos,
    output logic       left_btn,
    output logic       right_btn,
    output logic       middle_btn,
    output logic       packet_valid,
    output logic       sync_error,
    output logic [3:0] wheel_delta
);

    localparam logic [16:0] TIMER_LAST = 17'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [16:0] timer;
    logic [2:0]  b0_btn;
    logic        b0_sx;
    logic        b0_sy;
    logic        b0_ovf;
    logic [7:0]  b1_q;
    logic        final_byte;
    logic        move;
    logic [7:0]  dy_low;
    logic signed [8:0] dx;
    logic signed [8:0] dy;

`ifdef PS2_MOUSE_WHEEL_EN
    logic [7:0] b2_q;
    assign final_byte = received_data_en && (state == WAIT_B3);
    assign dy_low     = b2_q;
`else
    assign final_byte  = received_data_en && (state == WAIT_B2);
    assign dy_low      = received_data;
    assign wheel_delta = 4'h0;
`endif

    assign dx   = {b0_sx, b1_q};
    assign dy   = {b0_sy, dy_low};
    assign move = final_byte && !b0_ovf;

    ps2_axis_accumulator #(
        .W(10), .MAX(X_MAX), .INIT(X_INIT), .SHIFT(SHIFT_X), .INVERT(0)
    ) u_axis_x (
        .clk(clk), .reset_n(reset_n), .update(move), .delta(dx), .pos(x_pos)
    );

    ps2_axis_accumulator #(
        .W(9), .MAX(Y_MAX), .INIT(Y_INIT), .SHIFT(SHIFT_Y), .INVERT(1)
    ) u_axis_y (
        .clk(clk), .reset_n(reset_n), .update(move), .delta(dy), .pos(y_pos)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= WAIT_B0;
            timer        <= '0;
            b0_btn       <= '0;
            b0_sx        <= 1'b0;
            b0_sy        <= 1'b0;
            b0_ovf       <= 1'b0;
            b1_q         <= '0;
            left_btn     <= 1'b0;
            right_btn    <= 1'b0;
            middle_btn   <= 1'b0;
            packet_valid <= 1'b0;
            sync_error   <= 1'b0;
`ifdef PS2_MOUSE_WHEEL_EN
            b2_q         <= '0;
            wheel_delta  <= 4'h0;
`endif
        end else begin
            packet_valid <= 1'b0;
            sync_error   <= 1'b0;
            if (received_data_en) begin
                // a byte arriving on the expiry cycle still counts
                timer <= '0;
                case (state)
                    WAIT_B0: begin
                        if (received_data == PS2_ACK || received_data == PS2_BAT_OK) begin
                            state <= WAIT_B0;
                        end else if (!received_data[3]) begin
                            sync_error <= 1'b1;
                        end else begin
                            b0_btn <= received_data[2:0];
                            b0_sx  <= received_data[4];
                            b0_sy  <= received_data[5];
                            b0_ovf <= received_data[6] | received_data[7];
                            state  <= WAIT_B1;
                        end
                    end
                    WAIT_B1: begin
                        b1_q  <= received_data;
                        state <= WAIT_B2;
                    end
`ifdef PS2_MOUSE_WHEEL_EN
                    WAIT_B2: begin
                        b2_q  <= received_data;
                        state <= WAIT_B3;
                    end
                    WAIT_B3: begin
                        wheel_delta  <= received_data[3:0];
                        {middle_btn, right_btn, left_btn} <= b0_btn;
                        packet_valid <= 1'b1;
                        state        <= WAIT_B0;
                    end
`else
                    WAIT_B2: begin
                        {middle_btn, right_btn, left_btn} <= b0_btn;
                        packet_valid <= 1'b1;
                        state        <= WAIT_B0;
                    end
`endif
                    default: state <= WAIT_B0;
                endcase
            end else if (state != WAIT_B0) begin
                if (timer == TIMER_LAST) begin
                    state      <= WAIT_B0;
                    sync_error <= 1'b1;
                    timer      <= '0;
                end else begin
                    timer <= timer + 17'd1;
                end
            end
        end
    end

endmodule
